// File: rtl/int_div_pkg.sv
// Shared types and constants for the variable-latency iterative divider.
package int_div_pkg;

  localparam int unsigned DEFAULT_NBITS = 32;
  localparam int unsigned MSG_W         = 2 * DEFAULT_NBITS;

  // Message field positions: request {a, b}, response {quot, rem}
  localparam int unsigned HI_LSB = DEFAULT_NBITS;
  localparam int unsigned HI_MSB = 2 * DEFAULT_NBITS - 1;
  localparam int unsigned LO_LSB = 0;
  localparam int unsigned LO_MSB = DEFAULT_NBITS - 1;

  localparam logic [DEFAULT_NBITS-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/int_div_var_if.sv
// val/rdy request/response bundle shared by the divider and its source/sink harness.
interface int_div_var_if
  import int_div_pkg::*;
#(
  parameter int unsigned NBITS = DEFAULT_NBITS
);
  logic               req_val;
  logic               req_rdy;
  logic [2*NBITS-1:0] req_msg;
  logic               resp_val;
  logic               resp_rdy;
  logic [2*NBITS-1:0] resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/int_div_clz.sv
// Combinational leading-zero count; an all-zero input reports NBITS.
module int_div_clz #(
  parameter int unsigned NBITS = 32
) (
  input  logic [NBITS-1:0]       a_i,
  output logic [$clog2(NBITS):0] clz_o
);

  // Highest set bit wins because the scan runs LSB to MSB and overwrites.
  always_comb begin
    clz_o = ($clog2(NBITS) + 1)'(NBITS);
    for (int i = 0; i < NBITS; i++) begin
      clz_o = a_i[i] ? ($clog2(NBITS) + 1)'(NBITS - 1 - i) : clz_o;
    end
  end

endmodule

// File: rtl/int_div_var.sv
// Iterative unsigned divider: one quotient bit per cycle after skipping the
// dividend's leading zeros; divide-by-zero and a<b finish without iterating.
module int_div_var
  import int_div_pkg::*;
#(
  parameter int unsigned NBITS = DEFAULT_NBITS
) (
  input logic          clk,
  input logic          reset,
  int_div_var_if.slave bus
);

  localparam int unsigned CW = $clog2(NBITS) + 1;

  state_e           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d;
  logic [NBITS-1:0] b_q, b_d;
  logic [NBITS-1:0] quot_q, quot_d;
  logic [NBITS-1:0] rem_q, rem_d;
  logic [CW-1:0]    count_q, count_d;
  logic             req_rdy_q, req_rdy_d;
  logic             resp_val_q, resp_val_d;

  logic [NBITS-1:0] a_in_s;
  logic [NBITS-1:0] b_in_s;
  logic [CW-1:0]    clz_s;
  logic             req_fire_s;
  logic             resp_fire_s;
  logic             short_s;
  logic [NBITS:0]   rem_t_s;
  logic [NBITS:0]   diff_s;
  logic             ge_s;

  assign a_in_s      = bus.req_msg[2*NBITS-1:NBITS];
  assign b_in_s      = bus.req_msg[NBITS-1:0];
  assign req_fire_s  = bus.req_val & req_rdy_q;
  assign resp_fire_s = resp_val_q & bus.resp_rdy;
  assign short_s     = (b_in_s == '0) || (a_in_s < b_in_s);

  // The compare/subtract is one bit wider than the operands so the shifted-in
  // remainder never overflows.
  assign rem_t_s = {rem_q, a_q[NBITS-1]};
  assign diff_s  = rem_t_s - {1'b0, b_q};
  assign ge_s    = (rem_t_s >= {1'b0, b_q});

  int_div_clz #(.NBITS(NBITS)) u_clz (
    .a_i   (a_in_s),
    .clz_o (clz_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      count_q    <= '0;
      req_rdy_q  <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      count_q    <= count_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire_s) begin
          state_d = short_s ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC:    state_d = (count_q == CW'(1)) ? DONE : CALC;
      DONE:    state_d = resp_fire_s ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: operand latch on accept, one restoring step per CALC cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (req_fire_s) begin
          b_d = b_in_s;
          if (b_in_s == '0) begin
            a_d     = a_in_s;
            quot_d  = {NBITS{1'b1}};
            rem_d   = a_in_s;
            count_d = '0;
          end else if (a_in_s < b_in_s) begin
            a_d     = a_in_s;
            quot_d  = '0;
            rem_d   = a_in_s;
            count_d = '0;
          end else begin
            a_d     = a_in_s << clz_s;
            quot_d  = '0;
            rem_d   = '0;
            count_d = CW'(NBITS) - clz_s;
          end
        end else begin
          a_d = a_q;
        end
      end
      CALC: begin
        rem_d   = ge_s ? diff_s[NBITS-1:0] : rem_t_s[NBITS-1:0];
        quot_d  = {quot_q[NBITS-2:0], ge_s};
        a_d     = a_q << 1;
        count_d = count_q - CW'(1);
      end
      DONE:    a_d = a_q;
      default: a_d = a_q;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_comb begin
    req_rdy_d  = (state_d == IDLE);
    resp_val_d = (state_d == DONE);
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.resp_val = resp_val_q;
  assign bus.resp_msg = {quot_q, rem_q};

endmodule

// File: tb/tb_int_div_var.sv
// Directed and random self-checking bench for int_div_var.
module tb_int_div_var;
  import int_div_pkg::*;

  localparam int N = DEFAULT_NBITS;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  int_div_var_if #(.NBITS(N)) bus ();

  int_div_var #(.NBITS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int ref_clz(input logic [N-1:0] v);
    int c = N;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        c = N - 1 - i;
        break;
      end
    end
    return c;
  endfunction

  function automatic int ref_lat(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0 || a < b) return 1;
    return N - ref_clz(a) + 1;
  endfunction

  function automatic logic [2*N-1:0] ref_msg(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return {DIV0_QUOT, a};
    return {a / b, a % b};
  endfunction

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp_msg, input int exp_lat,
                        input int hold, input int pre);
    int w;
    int n;
    repeat (pre) @(negedge clk);
    @(negedge clk);
    w = 0;
    while (!bus.req_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, ":req_rdy"}, {63'd0, bus.req_rdy}, 64'd1);
    bus.req_val = 1'b1;
    bus.req_msg = {a, b};
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    bus.req_msg = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_val && n < 100);
    chk({tag, ":latency"}, 64'(n), 64'(exp_lat));
    chk({tag, ":msg"}, bus.resp_msg, exp_msg);
    chk({tag, ":busy_rdy"}, {63'd0, bus.req_rdy}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ":hold_val"}, {63'd0, bus.resp_val}, 64'd1);
      chk({tag, ":hold_msg"}, bus.resp_msg, exp_msg);
      chk({tag, ":hold_rdy"}, {63'd0, bus.req_rdy}, 64'd0);
    end
    bus.resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_rdy = 1'b0;
    @(negedge clk);
    chk({tag, ":post_rdy"}, {63'd0, bus.req_rdy}, 64'd1);
    chk({tag, ":post_val"}, {63'd0, bus.resp_val}, 64'd0);
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         seen;
    int           w;

    reset        = 1'b1;
    bus.req_val  = 1'b0;
    bus.req_msg  = '0;
    bus.resp_rdy = 1'b0;
    #1;
    chk("rst_req_rdy", {63'd0, bus.req_rdy}, 64'd0);
    chk("rst_resp_val", {63'd0, bus.resp_val}, 64'd0);
    chk("rst_resp_msg", bus.resp_msg, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy_rise", {63'd0, bus.req_rdy}, 64'd1);

    run_op("100/7",  32'd100, 32'd7, {32'h0000000e, 32'h00000002}, 8, 0, 0);
    run_op("5/0",    32'd5,   32'd0, {32'hffffffff, 32'h00000005}, 1, 0, 0);
    run_op("3/10",   32'd3,   32'd10, {32'h00000000, 32'h00000003}, 1, 0, 0);
    run_op("0/5",    32'd0,   32'd5, {32'h00000000, 32'h00000000}, 1, 0, 0);
    run_op("max/1",  32'hffffffff, 32'd1, {32'hffffffff, 32'h00000000}, 33, 0, 0);
    run_op("max/max", 32'hffffffff, 32'hffffffff, {32'h00000001, 32'h00000000}, 33, 0, 0);
    run_op("12/4",   32'd12,  32'd4, {32'h00000003, 32'h00000000}, 5, 5, 0);

    // Reset in the middle of a CALC sequence
    @(negedge clk);
    w = 0;
    while (!bus.req_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.req_val = 1'b1;
    bus.req_msg = {32'd1000, 32'd3};
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    bus.req_msg = '0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_val", {63'd0, bus.resp_val}, 64'd0);
    chk("midrst_rdy", {63'd0, bus.req_rdy}, 64'd0);
    chk("midrst_msg", bus.resp_msg, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | bus.resp_val;
    end
    chk("midrst_no_resp", {63'd0, seen}, 64'd0);
    chk("midrst_idle_rdy", {63'd0, bus.req_rdy}, 64'd1);
    run_op("9/2", 32'd9, 32'd2, {32'h00000004, 32'h00000001}, 5, 0, 0);

    // Random sweep with varied operand magnitudes and handshake delays
    for (int i = 0; i < 500; i++) begin
      ra = $urandom() >> $urandom_range(0, 31);
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = $urandom() >> $urandom_range(0, 31);
        2:       rb = $urandom();
        default: rb = ra >> $urandom_range(0, 8);
      endcase
      run_op("rand", ra, rb, ref_msg(ra, rb), ref_lat(ra, rb),
             $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
